// File: rtl/msdap_ctrl_if.sv
// Signal bundle between the MSDAP controller and its receiver/datapath/memories.
// XAW sets the data-memory address width.
interface msdap_ctrl_if #(
    parameter int XAW = 8
);
    // word_valid and compute_done are single-cycle strobes with no backpressure:
    // a word is taken whenever word_valid is high, and InReady is advisory only.
    logic           Reset;
    logic           word_valid;
    logic [15:0]    data_l;
    logic [15:0]    data_r;
    logic           compute_done;

    logic           InReady;
    logic [3:0]     state;
    logic           rj_we;
    logic [3:0]     rj_addr;
    logic           co_we;
    logic [8:0]     co_addr;
    logic           x_we;
    logic           x_clr;
    logic [XAW-1:0] x_addr;
    logic           compute_start;
    logic           overrun;

    modport slave (
        input  Reset, word_valid, data_l, data_r, compute_done,
        output InReady, state, rj_we, rj_addr, co_we, co_addr,
               x_we, x_clr, x_addr, compute_start, overrun
    );

    modport master (
        output Reset, word_valid, data_l, data_r, compute_done,
        input  InReady, state, rj_we, rj_addr, co_we, co_addr,
               x_we, x_clr, x_addr, compute_start, overrun
    );
endinterface

// File: rtl/msdap_ctrl.sv
// MSDAP control FSM: data-memory sweep, Rj/coefficient load, sample dispatch and clear.
// Define SLEEP_EN to add zero-run detection and the SLEEPING state.
module msdap_ctrl #(
    parameter int ZERO_LIMIT = 800,
    parameter int XAW        = 8
) (
    input logic         Sclk,
    input logic         Start,
    msdap_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        INIT     = 4'd0,
        WAIT_RJ  = 4'd1,
        READ_RJ  = 4'd2,
        WAIT_CO  = 4'd3,
        READ_CO  = 4'd4,
        WAIT_IN  = 4'd5,
        WORKING  = 4'd6,
        CLEARING = 4'd7,
        SLEEPING = 4'd8
    } state_e;

    state_e         state_q, state_d;
    logic [XAW:0]   sweep_q, sweep_d;
    logic [3:0]     rj_cnt_q, rj_cnt_d;
    logic [8:0]     co_cnt_q, co_cnt_d;
    logic [XAW-1:0] wptr_q, wptr_d;
    logic           busy_q, busy_d;
    logic           overrun_q, overrun_d;
    logic           rj_we_q, rj_we_d;
    logic [3:0]     rj_addr_q, rj_addr_d;
    logic           co_we_q, co_we_d;
    logic [8:0]     co_addr_q, co_addr_d;
    logic           x_we_q, x_we_d;
    logic           x_clr_q, x_clr_d;
    logic [XAW-1:0] x_addr_q, x_addr_d;
    logic           cs_q, cs_d;
    logic           store;
    logic           clear_req;

`ifdef SLEEP_EN
    localparam int            ZW   = $clog2(ZERO_LIMIT + 1);
    localparam logic [ZW-1:0] ZLIM = ZW'(ZERO_LIMIT);

    logic [ZW-1:0] zero_q, zero_d;
    logic [ZW-1:0] zero_inc;
    logic          sample_zero;

    assign sample_zero = (bus.data_l == 16'd0) && (bus.data_r == 16'd0);
    assign zero_inc    = (zero_q == ZLIM) ? zero_q : zero_q + {{(ZW-1){1'b0}}, 1'b1};
`else
    // Sample data only matters for zero-run detection, which this build omits.
    logic unused_ok;
    assign unused_ok = (^{bus.data_l, bus.data_r}) ^ (ZERO_LIMIT == 0);
`endif

    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        rj_cnt_d  = rj_cnt_q;
        co_cnt_d  = co_cnt_q;
        wptr_d    = wptr_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        rj_we_d   = 1'b0;
        rj_addr_d = rj_addr_q;
        co_we_d   = 1'b0;
        co_addr_d = co_addr_q;
        x_we_d    = 1'b0;
        x_clr_d   = 1'b0;
        x_addr_d  = x_addr_q;
        cs_d      = 1'b0;
        store     = 1'b0;
        clear_req = 1'b0;
`ifdef SLEEP_EN
        zero_d    = zero_q;
`endif

        if (bus.compute_done) busy_d = 1'b0;

        case (state_q)
            INIT, CLEARING: begin
                // Top bit of the sweep counter marks that every entry has been zeroed.
                if (sweep_q[XAW]) begin
                    sweep_d = '0;
                    state_d = (state_q == INIT) ? WAIT_RJ : WAIT_IN;
                end else begin
                    x_we_d   = 1'b1;
                    x_clr_d  = 1'b1;
                    x_addr_d = sweep_q[XAW-1:0];
                    sweep_d  = sweep_q + {{XAW{1'b0}}, 1'b1};
                end
            end
            WAIT_RJ, READ_RJ: begin
                if (bus.word_valid) begin
                    rj_we_d   = 1'b1;
                    rj_addr_d = rj_cnt_q;
                    rj_cnt_d  = rj_cnt_q + 4'd1;
                    state_d   = (rj_cnt_q == 4'd15) ? WAIT_CO : READ_RJ;
                end
            end
            WAIT_CO, READ_CO: begin
                if (bus.word_valid) begin
                    co_we_d   = 1'b1;
                    co_addr_d = co_cnt_q;
                    co_cnt_d  = co_cnt_q + 9'd1;
                    state_d   = (co_cnt_q == 9'd511) ? WAIT_IN : READ_CO;
                end
            end
            WAIT_IN: begin
                if (bus.word_valid) begin
                    store   = 1'b1;
                    state_d = WORKING;
`ifdef SLEEP_EN
                    zero_d  = sample_zero ? zero_inc : '0;
`endif
                end
            end
            WORKING: begin
                if (bus.Reset) begin
                    clear_req = 1'b1;
                end else if (bus.word_valid) begin
                    store = 1'b1;
`ifdef SLEEP_EN
                    zero_d = sample_zero ? zero_inc : '0;
                    if (sample_zero && (zero_inc == ZLIM)) state_d = SLEEPING;
`endif
                end
            end
`ifdef SLEEP_EN
            SLEEPING: begin
                if (bus.Reset) begin
                    clear_req = 1'b1;
                end else if (bus.word_valid && !sample_zero) begin
                    store   = 1'b1;
                    zero_d  = '0;
                    state_d = WORKING;
                end
            end
`endif
            default: state_d = INIT;
        endcase

        if (store) begin
            x_we_d   = 1'b1;
            x_addr_d = wptr_q;
            cs_d     = 1'b1;
            wptr_d   = wptr_q + {{(XAW-1){1'b0}}, 1'b1};
            busy_d   = 1'b1;
            if (busy_q) overrun_d = 1'b1;
        end

        if (clear_req) begin
            state_d = CLEARING;
            sweep_d = '0;
            wptr_d  = '0;
            busy_d  = 1'b0;
`ifdef SLEEP_EN
            zero_d  = '0;
`endif
        end
    end

    always_ff @(posedge Sclk) begin
        if (Start) begin
            state_q   <= INIT;
            sweep_q   <= '0;
            rj_cnt_q  <= '0;
            co_cnt_q  <= '0;
            wptr_q    <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            rj_we_q   <= 1'b0;
            rj_addr_q <= '0;
            co_we_q   <= 1'b0;
            co_addr_q <= '0;
            x_we_q    <= 1'b0;
            x_clr_q   <= 1'b0;
            x_addr_q  <= '0;
            cs_q      <= 1'b0;
`ifdef SLEEP_EN
            zero_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            rj_cnt_q  <= rj_cnt_d;
            co_cnt_q  <= co_cnt_d;
            wptr_q    <= wptr_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            rj_we_q   <= rj_we_d;
            rj_addr_q <= rj_addr_d;
            co_we_q   <= co_we_d;
            co_addr_q <= co_addr_d;
            x_we_q    <= x_we_d;
            x_clr_q   <= x_clr_d;
            x_addr_q  <= x_addr_d;
            cs_q      <= cs_d;
`ifdef SLEEP_EN
            zero_q    <= zero_d;
`endif
        end
    end

    assign bus.InReady       = (state_q != INIT) && (state_q != CLEARING);
    assign bus.state         = state_q;
    assign bus.rj_we         = rj_we_q;
    assign bus.rj_addr       = rj_addr_q;
    assign bus.co_we         = co_we_q;
    assign bus.co_addr       = co_addr_q;
    assign bus.x_we          = x_we_q;
    assign bus.x_clr         = x_clr_q;
    assign bus.x_addr        = x_addr_q;
    assign bus.compute_start = cs_q;
    assign bus.overrun       = overrun_q;

endmodule
